// File: rtl/slot_spin_controller.sv
// slot_spin_controller
//
// Sequencing controller for the slot-machine datapath. Holds the three reel
// registers and the credit balance. A spin request deducts the wager and
// starts all reels; each tick advances every running reel by its own step
// (modulo NUM_SYMBOLS). Stop pulses freeze the reels in order 1, 2, 3. After
// the third stop the external evaluator's multiplier (computed from
// card_1..card_3) is sampled, and the payout bet * multiplier is added into
// a saturating credit register.
//
// Ports:
//   clk           system clock, rising-edge active
//   rst_n         synchronous active-low reset
//   spin          one-cycle request to start a spin
//   stop          one-cycle request to stop the next running reel
//   tick          reel advance strobe
//   bet           wager, sampled on an accepted spin
//   multiplier    evaluator result for the current cards
//   card_1..3     reel values
//   credits       current balance
//   busy          high whenever a spin is in progress
//   result_valid  one-cycle pulse when the payout is applied
//   last_payout   bet * multiplier of the most recent spin
//   reject        one-cycle pulse when a spin request is refused
module slot_spin_controller #(
  parameter int NUM_SYMBOLS  = 8,
  parameter int CREDIT_W     = 10,
  parameter int INIT_CREDITS = 100,
  parameter int STEP_1       = 1,
  parameter int STEP_2       = 3,
  parameter int STEP_3       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spin,
  input  logic                stop,
  input  logic                tick,
  input  logic [3:0]          bet,
  input  logic [2:0]          multiplier,
  output logic [2:0]          card_1,
  output logic [2:0]          card_2,
  output logic [2:0]          card_3,
  output logic [CREDIT_W-1:0] credits,
  output logic                busy,
  output logic                result_valid,
  output logic [6:0]          last_payout,
  output logic                reject
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RUN3 = 3'd1;
  localparam logic [2:0] RUN2 = 3'd2;
  localparam logic [2:0] RUN1 = 3'd3;
  localparam logic [2:0] EVAL = 3'd4;
  localparam logic [2:0] PAY  = 3'd5;

  localparam logic [3:0] NSYM = 4'(NUM_SYMBOLS);
  localparam logic [3:0] S1   = 4'(STEP_1);
  localparam logic [3:0] S2   = 4'(STEP_2);
  localparam logic [3:0] S3   = 4'(STEP_3);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX  = '1;
  localparam logic [CREDIT_W-1:0] CREDIT_INIT = CREDIT_W'(INIT_CREDITS);
  // Sum wide enough for credits plus a 7-bit payout without wrapping.
  localparam int SUM_W = ((CREDIT_W > 7) ? CREDIT_W : 7) + 1;

  logic [2:0] state;
  logic [3:0] bet_q;
  logic       accept;
  logic       adv_1;
  logic       adv_2;
  logic       adv_3;

  // Step is always < NUM_SYMBOLS, so one conditional subtract is enough.
  function automatic logic [2:0] reel_next(input logic [2:0] card,
                                           input logic [3:0] step);
    logic [3:0] sum;
    sum = {1'b0, card} + step;
    if (sum >= NSYM) sum = sum - NSYM;
    return sum[2:0];
  endfunction

  function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] c,
                                                  input logic [6:0]          p);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(c) + SUM_W'(p);
    if (sum > SUM_W'(CREDIT_MAX)) return CREDIT_MAX;
    return sum[CREDIT_W-1:0];
  endfunction

  assign busy   = (state != IDLE);
  assign accept = (bet != 4'd0) && (credits >= CREDIT_W'(bet));

  // The reel being stopped in this cycle freezes at its pre-edge value even
  // if tick is also present; reels further down the line keep advancing.
  assign adv_1 = tick && (state == RUN3) && !stop;
  assign adv_2 = tick && ((state == RUN3) || ((state == RUN2) && !stop));
  assign adv_3 = tick && ((state == RUN3) || (state == RUN2) ||
                          ((state == RUN1) && !stop));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      card_1       <= 3'd0;
      card_2       <= 3'd0;
      card_3       <= 3'd0;
      credits      <= CREDIT_INIT;
      bet_q        <= 4'd0;
      last_payout  <= 7'd0;
      result_valid <= 1'b0;
      reject       <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      reject       <= 1'b0;

      if (adv_1) card_1 <= reel_next(card_1, S1);
      if (adv_2) card_2 <= reel_next(card_2, S2);
      if (adv_3) card_3 <= reel_next(card_3, S3);

      case (state)
        IDLE: begin
          if (spin) begin
            if (accept) begin
              credits <= credits - CREDIT_W'(bet);
              bet_q   <= bet;
              state   <= RUN3;
            end else begin
              reject  <= 1'b1;
            end
          end
        end
        RUN3: if (stop) state <= RUN2;
        RUN2: if (stop) state <= RUN1;
        RUN1: if (stop) state <= EVAL;
        // Cards have been stable since the third stop, so the evaluator's
        // multiplier is settled by this edge.
        EVAL: begin
          last_payout <= {3'b000, bet_q} * {4'b0000, multiplier};
          state       <= PAY;
        end
        PAY: begin
          credits      <= sat_add(credits, last_payout);
          result_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slot_spin_controller.sv
// Self-checking bench for slot_spin_controller: directed scenarios followed
// by random stimulus, checked against a behavioural reference model with an
// event scoreboard for result_valid / reject pulses.
module tb_slot_spin_controller;

  localparam int NS   = 8;
  localparam int CW   = 7;
  localparam int INIT = 100;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spin = 1'b0;
  logic          stop = 1'b0;
  logic          tick = 1'b0;
  logic [3:0]    bet = 4'd0;
  logic [2:0]    multiplier;
  logic [2:0]    card_1, card_2, card_3;
  logic [CW-1:0] credits;
  logic          busy, result_valid, reject;
  logic [6:0]    last_payout;

  bit            force_en = 1'b0;
  logic [2:0]    force_val = 3'd0;
  bit            mon_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  slot_spin_controller #(
    .NUM_SYMBOLS(NS), .CREDIT_W(CW), .INIT_CREDITS(INIT),
    .STEP_1(1), .STEP_2(3), .STEP_3(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spin(spin), .stop(stop), .tick(tick),
    .bet(bet), .multiplier(multiplier),
    .card_1(card_1), .card_2(card_2), .card_3(card_3),
    .credits(credits), .busy(busy), .result_valid(result_valid),
    .last_payout(last_payout), .reject(reject)
  );

  // Stand-in for the combinational result evaluator.
  function automatic logic [2:0] eval_f(input int a, input int b, input int c);
    if (a == b && b == c) return 3'd7;
    if (a == b) return 3'd3;
    if ((a + b + c) % 4 == 0) return 3'd1;
    return 3'd0;
  endfunction

  assign multiplier = force_en ? force_val
                               : eval_f(int'(card_1), int'(card_2), int'(card_3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit is_rv;
    int payout;
    int credits;
  } ev_t;
  ev_t ev_q[$];

  int steps[3] = '{1, 3, 5};
  int m_card[3];
  int m_credits;
  bit m_busy;
  int m_stopped;  // number of reels stopped in the current spin
  int m_phase;    // 0 reels spinning, 1 awaiting evaluation, 2 awaiting payout
  int m_bet;
  int m_payout;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_card = '{0, 0, 0};
        m_credits = INIT;
        m_busy = 0; m_stopped = 0; m_phase = 0; m_bet = 0; m_payout = 0;
        ev_q.delete();
      end else if (!m_busy) begin
        if (spin) begin
          if (bet != 0 && m_credits >= int'(bet)) begin
            m_credits -= int'(bet);
            m_bet = int'(bet);
            m_busy = 1; m_stopped = 0; m_phase = 0;
          end else begin
            ev_q.push_back('{0, 0, m_credits});
          end
        end
      end else if (m_phase == 1) begin
        m_payout = m_bet * int'(force_en ? force_val
                                         : eval_f(m_card[0], m_card[1], m_card[2]));
        m_phase = 2;
      end else if (m_phase == 2) begin
        m_credits = (m_credits + m_payout > CMAX) ? CMAX : m_credits + m_payout;
        m_busy = 0; m_phase = 0;
        ev_q.push_back('{1, m_payout, m_credits});
      end else begin
        for (int k = 0; k < 3; k++)
          if (tick && k >= m_stopped && !(stop && k == m_stopped))
            m_card[k] = (m_card[k] + steps[k]) % NS;
        if (stop) begin
          m_stopped++;
          if (m_stopped == 3) m_phase = 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("card_1", card_1, m_card[0]);
        chk("card_2", card_2, m_card[1]);
        chk("card_3", card_3, m_card[2]);
        chk("credits", credits, m_credits);
        chk("busy", busy, m_busy);
        chk("last_payout", last_payout, m_payout);
        if (result_valid || reject) begin
          if (ev_q.size() == 0) begin
            chk("unexpected_pulse", {result_valid, reject}, 0);
          end else begin
            e = ev_q.pop_front();
            chk("pulse_kind", {result_valid, reject}, e.is_rv ? 2 : 1);
            chk("pulse_credits", credits, e.credits);
            if (e.is_rv) chk("pulse_payout", last_payout, e.payout);
          end
        end else if (ev_q.size() > 0) begin
          e = ev_q.pop_front();
          chk("missing_pulse", {result_valid, reject}, e.is_rv ? 2 : 1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit s, input bit p, input bit t, input int b);
    spin = s; stop = p; tick = t; bet = 4'(b);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic full_spin(input int b);
    step(1, 0, 0, b);
    repeat (3) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    mon_en = 1'b1;
    chk("rst_credits", credits, 100);
    chk("rst_cards", {card_1, card_2, card_3}, 0);
    chk("rst_busy", busy, 0);

    // Basic payout with multiplier forced to 3.
    force_en = 1'b1; force_val = 3'd3;
    step(1, 0, 0, 5);
    chk("spin_credits", credits, 95);
    chk("spin_busy", busy, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("rv_at_stop3", result_valid, 0);
    step(0, 0, 0, 0);
    chk("rv_at_eval", result_valid, 0);
    step(0, 0, 0, 0);
    chk("rv_at_pay", result_valid, 1);
    chk("pay_payout", last_payout, 15);
    chk("pay_credits", credits, 110);
    step(0, 0, 0, 0);
    chk("rv_after", result_valid, 0);
    chk("busy_after", busy, 0);

    // Reel wrap from 0/0/0.
    force_en = 1'b0;
    step(1, 0, 0, 1);
    repeat (3) step(0, 0, 1, 0);
    chk("wrap3", {card_1, card_2, card_3}, {3'd3, 3'd1, 3'd7});
    step(0, 0, 1, 0);
    chk("wrap4", {card_1, card_2, card_3}, {3'd4, 3'd4, 3'd4});
    repeat (3) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);

    // Stop/tick collision, spin while busy, reset mid-spin.
    do_reset();
    step(1, 0, 0, 5);
    repeat (2) step(0, 0, 1, 0);
    chk("pre_collide", {card_1, card_2, card_3}, {3'd2, 3'd6, 3'd2});
    step(0, 1, 1, 0);
    chk("collide", {card_1, card_2, card_3}, {3'd2, 3'd1, 3'd7});
    step(1, 0, 0, 3);
    chk("busy_spin_reject", reject, 0);
    chk("busy_spin_credits", credits, 95);
    step(0, 0, 1, 0);
    chk("frozen_card_1", card_1, 2);
    step(0, 1, 0, 0);
    do_reset();
    chk("midrst_credits", credits, 100);
    chk("midrst_cards", {card_1, card_2, card_3}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rv", result_valid, 0);
    repeat (3) step(0, 0, 0, 0);

    // Refusals.
    step(1, 0, 0, 0);
    chk("bet0_reject", reject, 1);
    force_en = 1'b1; force_val = 3'd0;
    repeat (6) full_spin(15);
    full_spin(7);
    chk("drained", credits, 3);
    step(1, 0, 0, 5);
    chk("poor_reject", reject, 1);
    chk("poor_credits", credits, 3);
    chk("poor_busy", busy, 0);
    step(0, 0, 0, 0);

    // Saturation.
    do_reset();
    force_val = 3'd7;
    step(1, 0, 0, 15);
    chk("sat_deduct", credits, 85);
    repeat (3) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    chk("sat_payout", last_payout, 105);
    chk("sat_credits", credits, CMAX);

    // Random phase.
    force_en = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 39) == 0) begin
        force_en = $urandom_range(0, 1);
        force_val = 3'($urandom_range(0, 7));
      end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15));
    end
    rst_n = 1'b1;
    repeat (4) step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_empty", ev_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
